// File: rtl/spi_byte_master.sv
// Byte-level SPI master: serialises one byte on MOSI while capturing MISO, all four SPI modes.
// Optional `SPI_LSB_FIRST_EN selects LSB-first bit order; default is MSB first.
module spi_byte_master #(
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int SPI_MODE          = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_dv,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_dv,
  output logic       o_spi_clk,
  output logic       o_spi_mosi,
  input  logic       i_spi_miso
);

  localparam bit CPOL = 1'((SPI_MODE >> 1) & 1);
  localparam bit CPHA = 1'(SPI_MODE & 1);
  localparam int HW   = (CLKS_PER_HALF_BIT < 2) ? 1 : $clog2(CLKS_PER_HALF_BIT);
  localparam logic [HW-1:0] HALF_MAX = HW'(CLKS_PER_HALF_BIT - 1);

  generate
    if (CLKS_PER_HALF_BIT < 2) begin : g_bad_half_bit
      $error("spi_byte_master: CLKS_PER_HALF_BIT must be 2 or more");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [HW-1:0] half_cnt;
  logic [4:0]    edge_cnt;
  logic [7:0]    tx_shift;
  logic [7:0]    rx_shift;

  logic       tx_bit;
  logic [7:0] tx_next;
  logic [7:0] rx_next;
  logic [4:0] next_edge;
  logic       first_cycle;

`ifdef SPI_LSB_FIRST_EN
  assign tx_bit  = tx_shift[0];
  assign tx_next = {1'b0, tx_shift[7:1]};
  assign rx_next = {i_spi_miso, rx_shift[7:1]};
`else
  assign tx_bit  = tx_shift[7];
  assign tx_next = {tx_shift[6:0], 1'b0};
  assign rx_next = {rx_shift[6:0], i_spi_miso};
`endif

  assign next_edge   = edge_cnt + 5'd1;
  assign first_cycle = (edge_cnt == 5'd0) && (half_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      o_tx_ready <= 1'b1;
      o_rx_dv    <= 1'b0;
      o_rx_byte  <= 8'h00;
      o_spi_clk  <= CPOL;
      o_spi_mosi <= 1'b0;
      half_cnt   <= '0;
      edge_cnt   <= 5'd0;
      tx_shift   <= 8'h00;
      rx_shift   <= 8'h00;
    end else begin
      o_rx_dv <= 1'b0;
      case (state)
        IDLE: begin
          if (i_tx_dv) begin
            tx_shift   <= i_tx_byte;
            o_tx_ready <= 1'b0;
            half_cnt   <= '0;
            edge_cnt   <= 5'd0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          // CPHA=0 must present the first bit before the first leading edge
          if (!CPHA && first_cycle) begin
            o_spi_mosi <= tx_bit;
            tx_shift   <= tx_next;
          end
          if (half_cnt == HALF_MAX) begin
            half_cnt  <= '0;
            o_spi_clk <= ~o_spi_clk;
            edge_cnt  <= next_edge;
            if (next_edge[0]) begin
              if (CPHA) begin
                o_spi_mosi <= tx_bit;
                tx_shift   <= tx_next;
              end else begin
                rx_shift <= rx_next;
              end
            end else begin
              if (CPHA) begin
                rx_shift <= rx_next;
              end else if (next_edge != 5'd16) begin
                o_spi_mosi <= tx_bit;
                tx_shift   <= tx_next;
              end
            end
            if (next_edge == 5'd16) state <= DONE;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        DONE: begin
          o_rx_dv    <= 1'b1;
          o_rx_byte  <= rx_shift;
          o_tx_ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// Scoreboard bench for spi_byte_master: mode 0 / H=2 loopback instance and mode 3 / H=3 slave-model instance.
module tb_spi_byte_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] tx0, tx3;
  logic       dv0, dv3;
  logic       rdy0, rdy3, rxdv0, rxdv3, sclk0, sclk3, mosi0, mosi3;
  logic [7:0] rxb0, rxb3;
  logic       miso0, miso3;

  assign miso0 = mosi0;

  spi_byte_master #(.CLKS_PER_HALF_BIT(2), .SPI_MODE(0)) u0 (
    .clk(clk), .rst(rst), .i_tx_byte(tx0), .i_tx_dv(dv0), .o_tx_ready(rdy0),
    .o_rx_byte(rxb0), .o_rx_dv(rxdv0), .o_spi_clk(sclk0), .o_spi_mosi(mosi0),
    .i_spi_miso(miso0)
  );

  spi_byte_master #(.CLKS_PER_HALF_BIT(3), .SPI_MODE(3)) u3 (
    .clk(clk), .rst(rst), .i_tx_byte(tx3), .i_tx_dv(dv3), .o_tx_ready(rdy3),
    .o_rx_byte(rxb3), .o_rx_dv(rxdv3), .o_spi_clk(sclk3), .o_spi_mosi(mosi3),
    .i_spi_miso(miso3)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave for the mode 3 instance: shifts 8'h3C out on each falling SPI clock edge
  int         sl_cnt  = 0;
  logic [7:0] sl_byte = 8'h3C;
  always @(negedge sclk3 or posedge rdy3) begin
    if (rdy3) sl_cnt <= 0;
    else      sl_cnt <= sl_cnt + 1;
  end
  always_comb begin
    miso3 = 1'b0;
    if (sl_cnt >= 1 && sl_cnt <= 8) begin
`ifdef SPI_LSB_FIRST_EN
      miso3 = sl_byte[3'(sl_cnt - 1)];
`else
      miso3 = sl_byte[3'(8 - sl_cnt)];
`endif
    end
  end

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;
  exp_t q0[$];
  exp_t q3[$];
  exp_t e0, e3;

  always @(negedge clk) begin
    if (rxdv0 === 1'b1) begin
      if (q0.size() == 0) begin
        check("u0_unexpected_rx_dv", 32'(q0.size()), 1);
      end else begin
        e0 = q0.pop_front();
        check("u0_rx_byte", 32'(rxb0), 32'(e0.data));
        check("u0_rx_cycle", cyc, e0.at);
        check("u0_ready_at_dv", 32'(rdy0), 1);
        check("u0_clk_idle_at_dv", 32'(sclk0), 0);
      end
    end
    if (rxdv3 === 1'b1) begin
      if (q3.size() == 0) begin
        check("u3_unexpected_rx_dv", 32'(q3.size()), 1);
      end else begin
        e3 = q3.pop_front();
        check("u3_rx_byte", 32'(rxb3), 32'(e3.data));
        check("u3_rx_cycle", cyc, e3.at);
        check("u3_ready_at_dv", 32'(rdy3), 1);
        check("u3_clk_idle_at_dv", 32'(sclk3), 1);
      end
    end
  end

  task automatic send0(input logic [7:0] b, input logic [7:0] exp_mosi, input bit extra_pulse);
    int         t0;
    int         rises;
    logic       prev;
    logic [7:0] cap;
    @(negedge clk);
    tx0 = b;
    dv0 = 1'b1;
    t0  = cyc + 1;
    q0.push_back('{b, t0 + 33});
    @(negedge clk);
    dv0   = 1'b0;
    prev  = sclk0;
    rises = 0;
    cap   = 8'h00;
    while (cyc < t0 + 34) begin
      @(negedge clk);
      if (extra_pulse && cyc == t0 + 4) begin
        dv0 = 1'b1;
        tx0 = 8'hEE;
      end else begin
        dv0 = 1'b0;
      end
      if (sclk0 && !prev) begin
        check("u0_rise_cycle", cyc, t0 + 2 + 4 * rises);
        cap = {cap[6:0], mosi0};
        rises++;
      end
      prev = sclk0;
    end
    check("u0_rise_count", rises, 8);
    check("u0_mosi_seq", 32'(cap), 32'(exp_mosi));
  endtask

  task automatic wait_ready0(input logic v);
    int n;
    n = 0;
    while (rdy0 !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rdy0 !== v) check("u0_ready_wait", 32'(rdy0), 32'(v));
  endtask

  initial begin
    int   t0;
    int   rises;
    logic prev;
    rst = 1'b1;
    tx0 = 8'h00; dv0 = 1'b0;
    tx3 = 8'h00; dv3 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(rdy0), 1);
    check("rst_rx_dv", 32'(rxdv0), 0);
    check("rst_rx_byte", 32'(rxb0), 0);
    check("rst_spi_clk_mode0", 32'(sclk0), 0);
    check("rst_mosi", 32'(mosi0), 0);
    check("rst_spi_clk_mode3", 32'(sclk3), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Mode 0 loopback with a stray strobe mid-transfer
    send0(8'hA5, 8'hA5, 1'b1);
    repeat (3) @(negedge clk);

    // Mode 3 against the slave model
    check("u3_idle_high", 32'(sclk3), 1);
    tx3 = 8'hFF;
    dv3 = 1'b1;
    t0  = cyc + 1;
    q3.push_back('{8'h3C, t0 + 49});
    @(negedge clk);
    dv3   = 1'b0;
    prev  = sclk3;
    rises = 0;
    while (cyc < t0 + 52) begin
      @(negedge clk);
      if (sclk3 && !prev) rises++;
      prev = sclk3;
    end
    check("u3_rise_count", rises, 8);

    // Strobe held high across three bytes
    @(negedge clk);
    tx0 = 8'h11;
    dv0 = 1'b1;
    t0  = cyc + 1;
    q0.push_back('{8'h11, t0 + 33});
    q0.push_back('{8'h22, t0 + 67});
    q0.push_back('{8'h33, t0 + 101});
    wait_ready0(1'b0);
    tx0 = 8'h22;
    wait_ready0(1'b1);
    wait_ready0(1'b0);
    tx0 = 8'h33;
    wait_ready0(1'b1);
    wait_ready0(1'b0);
    dv0 = 1'b0;
    while (cyc < t0 + 104) @(negedge clk);

    // Reset during a transfer
    tx0 = 8'h5A;
    dv0 = 1'b1;
    t0  = cyc + 1;
    @(negedge clk);
    dv0 = 1'b0;
    while (cyc < t0 + 9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_spi_clk", 32'(sclk0), 0);
    check("abort_ready", 32'(rdy0), 1);
    check("abort_rx_dv", 32'(rxdv0), 0);
    repeat (40) @(negedge clk);
    send0(8'hC3, 8'hC3, 1'b0);

`ifdef SPI_LSB_FIRST_EN
    send0(8'h01, 8'h80, 1'b0);
`else
    send0(8'h01, 8'h01, 1'b0);
`endif
    repeat (5) @(negedge clk);

    check("u0_scoreboard_drained", 32'(q0.size()), 0);
    check("u3_scoreboard_drained", 32'(q3.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks made", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
